// File: rtl/message_pkg.sv
// Shared types and constants for the message scroller and its display path.
package message_pkg;

  localparam int SYM_W     = 5;
  localparam int IDX_W     = 4;
  localparam int ROM_DEPTH = 16;

  typedef enum logic {
    FILL,
    RUN
  } state_t;

  localparam logic [SYM_W-1:0] BLANK_SYM = 5'h1F;

  // Single conditional subtract: callers keep sum below 2*len.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [5:0] sum, input logic [5:0] len);
    return (sum >= len) ? IDX_W'(sum - len) : IDX_W'(sum);
  endfunction

endpackage

// File: rtl/message_scroller_tick_gen.sv
// Prescaler producing one tick every TICK_DIV enabled cycles; clr holds it at zero.
module tick_gen #(
  parameter int TICK_DIV = 12_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = en && !clr && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/message_scroller.sv
// Scrolls a DIGITS-wide symbol window over an external MSG_LEN-symbol ROM.
// Define MESSAGE_SCROLL_DIR_EN to add the dir port and reverse scrolling.
module message_scroller
  import message_pkg::*;
#(
  parameter int MSG_LEN  = 10,
  parameter int DIGITS   = 3,
  parameter int TICK_DIV = 12_000_000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en,
`ifdef MESSAGE_SCROLL_DIR_EN
  input  logic                      dir,
`endif
  output logic [IDX_W-1:0]          index,
  input  logic [SYM_W-1:0]          value,
  output logic [DIGITS*SYM_W-1:0]   window,
  output logic                      window_valid,
  output logic                      step
);

  localparam int WIN_W = DIGITS * SYM_W;
  localparam logic [5:0] LEN6    = 6'(MSG_LEN);
  localparam logic [5:0] FWD_OFS = 6'(DIGITS);
  localparam logic [5:0] REV_OFS = 6'(MSG_LEN - 1);
  localparam logic [IDX_W-1:0] FILL_LAST = IDX_W'(DIGITS - 1);

  state_t           state;
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] fill_cnt;
  logic             tick;
  logic [IDX_W-1:0] fwd_idx;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (state == FILL),
    .en     (en),
    .tick   (tick)
  );

  // Forward fetch address is also the head successor's right-hand symbol.
  assign fwd_idx = wrap_idx({2'b00, head} + FWD_OFS, LEN6);

  // NOTE: index gets a default before the branches so no latch is inferred.
  always_comb begin
    index = fill_cnt;
    if (state == RUN) begin
`ifdef MESSAGE_SCROLL_DIR_EN
      index = dir ? wrap_idx({2'b00, head} + REV_OFS, LEN6) : fwd_idx;
`else
      index = fwd_idx;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= FILL;
      head         <= '0;
      fill_cnt     <= '0;
      window       <= '0;
      window_valid <= 1'b0;
      step         <= 1'b0;
    end else begin
      step <= tick;
      case (state)
        FILL: begin
          window   <= {window[WIN_W-SYM_W-1:0], value};
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == FILL_LAST) begin
            state        <= RUN;
            window_valid <= 1'b1;
          end
        end
        RUN: begin
          if (tick) begin
`ifdef MESSAGE_SCROLL_DIR_EN
            if (dir) begin
              window <= {value, window[WIN_W-1:SYM_W]};
              head   <= wrap_idx({2'b00, head} + REV_OFS, LEN6);
            end else begin
              window <= {window[WIN_W-SYM_W-1:0], value};
              head   <= wrap_idx({2'b00, head} + 6'd1, LEN6);
            end
`else
            window <= {window[WIN_W-SYM_W-1:0], value};
            head   <= wrap_idx({2'b00, head} + 6'd1, LEN6);
`endif
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/message_scroller.md
# message_scroller

Sequencer that reads the 16-entry, 5-bit symbol message ROM by driving its index and sampling its combinational value. It builds a DIGITS-wide window of symbols and advances that window by one symbol per tick, wrapping around the MSG_LEN-symbol message. The window feeds the 7-segment display multiplexer, which decodes each 5-bit symbol.

## Interface
- MSG_LEN, 10: number of valid message symbols, indices 0..MSG_LEN-1. Legal range DIGITS ≤ MSG_LEN ≤ 16.
- DIGITS, 3: window width in symbols.
- TICK_DIV, 12_000_000: clock cycles per scroll step. Legal range ≥ 2.
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- en  in  1  scroll enable; the prescaler counts only while high.
- dir  in  1  0 = forward, 1 = reverse. Present only with MESSAGE_SCROLL_DIR_EN.
- index  out  4  ROM address.
- value  in  5  ROM data; combinational function of index.
- window  out  DIGITS*5  symbol window; the leftmost digit is window[DIGITS*5-1 -: 5].
- window_valid  out  1  high once the initial fill is complete.
- step  out  1  one-cycle pulse, asserted the cycle after the window advances.

## Operation
- State register with states FILL and RUN. Registers: head (4 b, index of the leftmost symbol), fill_cnt, prescaler, window, step.
- Reset values: state=FILL, head=0, fill_cnt=0, prescaler=0, window=0, window_valid=0, step=0. index therefore reads 0.
- FILL state:
  - index = fill_cnt.
  - Each cycle, window shifts left by 5 and value is appended at the right.
  - fill_cnt counts up; after the DIGITS-th sample, go to RUN with window_valid=1.
  - The prescaler is held at 0 and en is ignored.
- RUN state, index as a combinational function of head and dir:
  - forward: (head+DIGITS) mod MSG_LEN.
  - reverse: (head+MSG_LEN-1) mod MSG_LEN.
- Prescaler in RUN:
  - Increments while en=1 and holds its value while en=0; it is not cleared.
  - At prescaler==TICK_DIV-1 with en=1 (the tick cycle), prescaler returns to 0 and a step occurs.
- Forward step: window shifts left by 5, value enters the right digit, head = (head+1) mod MSG_LEN.
- Reverse step: window shifts right by 5, value enters the left digit, head = (head+MSG_LEN-1) mod MSG_LEN.
- dir is evaluated only on tick cycles. A change between ticks only re-points index.
- Modulo arithmetic: compute in 6 bits, then subtract MSG_LEN once if the result is ≥ MSG_LEN. This is exact because DIGITS ≤ MSG_LEN. ROM entries at index ≥ MSG_LEN are never addressed.
- Asynchronous reset mid-operation: all registers return to reset values immediately, independent of clk; FILL restarts on the first edge after release.

## Timing
- Fill latency: index=k during cycle k after reset release (k=0..DIGITS-1). window_valid rises at the edge ending cycle DIGITS-1.
- Scroll period: exactly TICK_DIV enabled cycles. The first tick occurs TICK_DIV cycles after entering RUN with en held high.
- window and head update on the edge ending the tick cycle. step is high for the following cycle only.
- index settles combinationally in the same cycle as any head, state or dir change. value must be valid within that cycle, since the ROM is combinational.
- No output depends combinationally on en.

## Configuration
- MESSAGE_SCROLL_DIR_EN defined: the dir port exists and reverse scrolling is supported as above.
- MESSAGE_SCROLL_DIR_EN undefined: the dir port is absent, direction is hard-wired forward, and the reverse index/shift logic is not synthesized.

## Structure
- Shared package message_pkg holds:
  - SYM_W=5, IDX_W=4, ROM_DEPTH=16.
  - State enum {FILL, RUN}.
  - BLANK_SYM constant, used by the display decoder.
- Sub-module tick_gen: parameter TICK_DIV; inputs clk, reset_n, clr, en; output tick. Instantiated once, with clr held high in FILL.
- The ROM itself stays external; this block only drives index and samples value.

## Test plan
Bench setup: MSG_LEN=10, DIGITS=3, TICK_DIV=4, and a ROM model returning value=index for indices 0..9.

- Reset release, en=0 -> index = 0,1,2 on cycles 0–2; window={0,1,2}; window_valid=1 from cycle 3; step never pulses; index then holds at 3.
- en=1, forward -> window advances every 4 cycles: {1,2,3}, {2,3,4} … {8,9,0}, {9,0,1}, {0,1,2} after 10 steps; one step pulse per advance.
- en dropped for 7 cycles with prescaler=2 -> the next step is delayed by exactly 7 cycles; prescaler resumes at 2.
- MESSAGE_SCROLL_DIR_EN defined, dir=1 at window {0,1,2} -> index=9; windows {9,0,1}, then {8,9,0}. Toggling dir between ticks changes only index.
- reset_n low mid-RUN, asserted between clock edges -> window=0, window_valid=0, step=0 immediately; after release the window refills to {0,1,2}.
- MSG_LEN=3 (equal to DIGITS), forward -> index cycles 0,1,2; windows {1,2,0}, {2,0,1}, {0,1,2}.
